clock_enable_scheduler: RTL and testbench
=========================================

Name: clock_enable_scheduler

Overview:
- Synthesizable controller that sequences a free-running clock into a gated clock-enable (ce) for downstream logic such as a core or peripheral under test.
- Supports three modes: halted, free-running at a programmable divide ratio, and stepping a fixed number of enable pulses.
- Lets benches and debug logic pause, resume and single-step a design without touching the clock itself.

Parameters:
DIV_WIDTH, 8, width of the divide ratio; the ce period is (div+1) clk cycles.
STEP_WIDTH, 16, width of the step count and remaining-step counter.

Ports:
clk  input  1  free-running clock.
rst  input  1  asynchronous, active-high reset.
cfg_valid  input  1  a new divide value is offered.
cfg_ready  output  1  always 1; cfg is accepted on any edge where cfg_valid=1.
cfg_div  input  DIV_WIDTH  new divide value.
cmd_valid  input  1  a command is offered.
cmd_ready  output  1  always 1; cmd is accepted on any edge where cmd_valid=1.
cmd_op  input  2  00=HALT, 01=RUN, 10=STEP, 11=reserved (treated as no-op).
cmd_count  input  STEP_WIDTH  number of ce pulses for STEP.
ce  output  1  clock enable, high for exactly one clk cycle per period.
running  output  1  high when state is RUNNING or STEPPING.
step_done  output  1  one-cycle pulse when a STEP completes.
steps_remaining  output  STEP_WIDTH  remaining ce pulses in STEPPING; 0 otherwise.

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous and active-high (rst).
- Reset values: state=HALTED, div=0, pending_valid=0, phase=0, remaining=0, step_done=0. Hence ce=0 and running=0.
- Registers:
  - state: HALTED / RUNNING / STEPPING.
  - div (DIV_WIDTH), plus pending_div and pending_valid.
  - phase counter (DIV_WIDTH).
  - remaining (STEP_WIDTH).
  - step_done flop.
- ce: combinational decode of registers only, ce = (state != HALTED) && (phase == div). No input reaches ce combinationally.
- Phase counter:
  - In RUNNING or STEPPING: increments each edge; when phase == div it wraps to 0.
  - In HALTED: held at 0.
  - Leaving HALTED: starts at 0.
  - Latency: a command accepted at edge E gives first ce in the cycle after E+div. div=0 gives ce in the cycle right after E; div=3 gives ce in the 4th cycle after E.
- Config:
  - An accepted cfg writes pending_div and sets pending_valid. If several arrive before they are applied, the last one wins.
  - Applied at the next wrap edge (phase == div while not HALTED) or at the next edge while HALTED. At that edge div <= pending_div, phase <= 0, pending_valid <= 0.
  - A cfg accepted on the wrap edge itself applies on that same edge.
- Commands (accepted at the edge where cmd_valid=1):
  - HALT: state <= HALTED, phase <= 0, remaining <= 0 from any state. An aborted STEP does not pulse step_done.
  - RUN: from HALTED, start with phase <= 0. From STEPPING, convert to RUNNING with phase preserved and remaining <= 0. From RUNNING, no effect.
  - STEP, count=0: no state change; step_done pulses in the next cycle.
  - STEP, count=N>0: state <= STEPPING, remaining <= N. Phase is cleared only if the previous state was HALTED. STEP while STEPPING reloads remaining with N.
- STEPPING countdown:
  - Each cycle with ce=1 decrements remaining at the following edge.
  - On the edge where ce=1 and remaining==1: state <= HALTED, remaining <= 0, phase <= 0, step_done <= 1 for one cycle.
  - A command accepted on that same edge takes priority over the auto-halt; no step_done in that case.
- Priority when cmd and cfg arrive on the same edge: cmd updates state/phase first, then cfg applies using the post-command state.
- Wrap-around: phase never exceeds div. Changing div can only occur via the pending mechanism, so phase > div is unreachable.
- Reserved op: accepted and ignored.

Test Plan:
1. Reset, RUN with div=0 -> ce high every cycle starting 1 cycle after the accept edge; running=1.
2. cfg_div=3 while HALTED, then RUN -> ce high once every 4 cycles, first ce 4 cycles after accept; 10 periods checked.
3. Running at div=3, cfg_div=1 offered at phase=1 -> current period completes (ce at phase 3), then period becomes 2 cycles; no short or double ce.
4. STEP count=5 at div=2 -> exactly 5 ce pulses spaced 3 cycles; steps_remaining counts 5→0; step_done pulses once, the cycle after the 5th ce; running drops with it.
5. STEP count=0 -> no ce, step_done pulses next cycle; HALT mid-STEP after 2 pulses -> ce stops immediately, no step_done, remaining=0.
6. rst asserted asynchronously mid-RUN at div=2 -> ce, running, steps_remaining go 0 without a clock edge; after release div reads back 0 (RUN gives ce every cycle).

Source files
------------

// File: rtl/clock_enable_scheduler_if.sv
// rtl/clock_enable_scheduler_if.sv - cfg and cmd handshake bundle for clock_enable_scheduler
//
// Purpose: carries the divide-ratio config channel and the HALT/RUN/STEP
// command channel between a controller (master) and the scheduler (slave).
// Signals:
//   cfg_valid/cfg_ready/cfg_div              divide ratio offer (ready is always 1)
//   cmd_valid/cmd_ready/cmd_op/cmd_count     command offer (ready is always 1)
interface clock_enable_scheduler_if #(
  parameter int DIV_WIDTH  = 8,
  parameter int STEP_WIDTH = 16
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [DIV_WIDTH-1:0]  cfg_div;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [STEP_WIDTH-1:0] cmd_count;

  modport master (
    output cfg_valid, cfg_div, cmd_valid, cmd_op, cmd_count,
    input  cfg_ready, cmd_ready
  );

  modport slave (
    input  cfg_valid, cfg_div, cmd_valid, cmd_op, cmd_count,
    output cfg_ready, cmd_ready
  );
endinterface

// File: rtl/clock_enable_scheduler.sv
// rtl/clock_enable_scheduler.sv - halt/run/step sequencer producing a divided clock enable
//
// Purpose: turns the free-running clk into a one-cycle-wide enable (ce) with
// period div+1, either continuously (RUNNING) or for a counted number of
// pulses (STEPPING), and holds it off while HALTED.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   bus (slave)       cfg and cmd handshake channels
//   ce                clock enable, registered-state decode only
//   running           state is RUNNING or STEPPING
//   step_done         one-cycle pulse when a STEP completes (or STEP with count 0)
//   steps_remaining   ce pulses still owed in STEPPING, 0 otherwise
module clock_enable_scheduler #(
  parameter int DIV_WIDTH  = 8,
  parameter int STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  clock_enable_scheduler_if.slave bus,
  output logic                  ce,
  output logic                  running,
  output logic                  step_done,
  output logic [STEP_WIDTH-1:0] steps_remaining
);

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } state_t;

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;

  state_t                state, state_n;
  logic [DIV_WIDTH-1:0]  div, div_n;
  logic [DIV_WIDTH-1:0]  pending_div, pending_div_n;
  logic                  pending_valid, pending_valid_n;
  logic [DIV_WIDTH-1:0]  phase, phase_n;
  logic [STEP_WIDTH-1:0] remaining, remaining_n;
  logic                  step_done_n;
  logic [DIV_WIDTH-1:0]  phase_adv;

  assign bus.cfg_ready = 1'b1;
  assign bus.cmd_ready = 1'b1;

  // ce doubles as the wrap condition: phase has reached div while enabled.
  assign ce              = (state != ST_HALTED) && (phase == div);
  assign running         = (state != ST_HALTED);
  assign steps_remaining = remaining;

  // Phase value for an enabled cycle that keeps counting.
  assign phase_adv = ce ? '0 : phase + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_HALTED;
      div           <= '0;
      pending_div   <= '0;
      pending_valid <= 1'b0;
      phase         <= '0;
      remaining     <= '0;
      step_done     <= 1'b0;
    end else begin
      state         <= state_n;
      div           <= div_n;
      pending_div   <= pending_div_n;
      pending_valid <= pending_valid_n;
      phase         <= phase_n;
      remaining     <= remaining_n;
      step_done     <= step_done_n;
    end
  end

  always_comb begin
    state_n         = state;
    div_n           = div;
    pending_div_n   = pending_div;
    pending_valid_n = pending_valid;
    phase_n         = phase;
    remaining_n     = remaining;
    step_done_n     = 1'b0;

    // Free-running behaviour with no command this edge.
    if (state == ST_HALTED) begin
      phase_n = '0;
    end else begin
      phase_n = phase_adv;
      if (state == ST_STEPPING && ce) begin
        if (remaining == STEP_WIDTH'(1)) begin
          state_n     = ST_HALTED;
          remaining_n = '0;
          phase_n     = '0;
          step_done_n = 1'b1;
        end else begin
          remaining_n = remaining - 1'b1;
        end
      end
    end

    // A command overrides the auto-halt above, including its step_done.
    if (bus.cmd_valid) begin
      case (bus.cmd_op)
        OP_HALT: begin
          state_n     = ST_HALTED;
          phase_n     = '0;
          remaining_n = '0;
          step_done_n = 1'b0;
        end
        OP_RUN: begin
          if (state == ST_HALTED) begin
            state_n = ST_RUNNING;
            phase_n = '0;
          end else if (state == ST_STEPPING) begin
            state_n     = ST_RUNNING;
            phase_n     = phase_adv;
            remaining_n = '0;
            step_done_n = 1'b0;
          end
        end
        OP_STEP: begin
          if (bus.cmd_count == '0) begin
            step_done_n = 1'b1;
          end else begin
            state_n     = ST_STEPPING;
            remaining_n = bus.cmd_count;
            step_done_n = 1'b0;
            phase_n     = (state == ST_HALTED) ? '0 : phase_adv;
          end
        end
        default: ;
      endcase
    end

    if (bus.cfg_valid) begin
      pending_div_n   = bus.cfg_div;
      pending_valid_n = 1'b1;
    end

    // New divide takes effect only on a period boundary so no short ce period
    // is ever produced; halted means there is no period in flight.
    if (pending_valid_n && (state_n == ST_HALTED || ce)) begin
      div_n           = pending_div_n;
      phase_n         = '0;
      pending_valid_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// tb/tb_clock_enable_scheduler.sv - directed vector bench for clock_enable_scheduler
module tb_clock_enable_scheduler;

  localparam logic [1:0] HALT = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] STEP = 2'b10;
  localparam logic [1:0] RSVD = 2'b11;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        running;
  logic        step_done;
  logic [15:0] steps_remaining;

  int total;
  int bad;

  clock_enable_scheduler_if #(.DIV_WIDTH(8), .STEP_WIDTH(16)) bus ();

  clock_enable_scheduler #(.DIV_WIDTH(8), .STEP_WIDTH(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .ce              (ce),
    .running         (running),
    .step_done       (step_done),
    .steps_remaining (steps_remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [7:0]  cd;
    logic        mv;
    logic [1:0]  op;
    logic [15:0] cnt;
    logic        ece;
    logic        erun;
    logic        esd;
    logic [15:0] erem;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic cv, input logic [7:0] cd, input logic mv,
                   input logic [1:0] op, input logic [15:0] cnt,
                   input logic ece, input logic erun, input logic esd,
                   input logic [15:0] erem);
    vec_t r;
    r = '{cv, cd, mv, op, cnt, ece, erun, esd, erem};
    vecs.push_back(r);
  endtask

  task automatic idle(input logic ece, input logic erun, input logic esd,
                      input logic [15:0] erem);
    v(1'b0, 8'd0, 1'b0, HALT, 16'd0, ece, erun, esd, erem);
  endtask

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic ece, input logic erun,
                            input logic esd, input logic [15:0] erem);
    check({tag, ".ce"}, {15'd0, ce}, {15'd0, ece});
    check({tag, ".running"}, {15'd0, running}, {15'd0, erun});
    check({tag, ".step_done"}, {15'd0, step_done}, {15'd0, esd});
    check({tag, ".steps_remaining"}, steps_remaining, erem);
  endtask

  // Offer inputs for one edge; return at edge+1 with valids dropped.
  task automatic cycle(input logic cv, input logic [7:0] cd, input logic mv,
                       input logic [1:0] op, input logic [15:0] cnt);
    bus.cfg_valid = cv;
    bus.cfg_div   = cd;
    bus.cmd_valid = mv;
    bus.cmd_op    = op;
    bus.cmd_count = cnt;
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = HALT;
    bus.cmd_count = '0;

    // 1: RUN at div=0, ce every cycle
    v(0, 0, 1, RUN, 0,  1, 1, 0, 0);
    idle(1, 1, 0, 0);
    idle(1, 1, 0, 0);
    v(0, 0, 1, HALT, 0, 0, 0, 0, 0);
    // 2: cfg div=3 while halted, RUN, first ce 4 cycles after accept
    v(1, 3, 0, HALT, 0, 0, 0, 0, 0);
    v(0, 0, 1, RUN, 0,  0, 1, 0, 0);
    idle(0, 1, 0, 0);
    idle(0, 1, 0, 0);
    idle(1, 1, 0, 0);
    idle(0, 1, 0, 0);
    // 3: cfg div=1 accepted at phase=1, takes effect after current period
    idle(0, 1, 0, 0);
    v(1, 1, 0, HALT, 0, 0, 1, 0, 0);
    idle(1, 1, 0, 0);
    idle(0, 1, 0, 0);
    idle(1, 1, 0, 0);
    idle(0, 1, 0, 0);
    idle(1, 1, 0, 0);
    v(0, 0, 1, HALT, 0, 0, 0, 0, 0);
    // 4: STEP 5 at div=2
    v(1, 2, 0, HALT, 0, 0, 0, 0, 0);
    v(0, 0, 1, STEP, 5, 0, 1, 0, 5);
    idle(0, 1, 0, 5); idle(1, 1, 0, 5);
    idle(0, 1, 0, 4); idle(0, 1, 0, 4); idle(1, 1, 0, 4);
    idle(0, 1, 0, 3); idle(0, 1, 0, 3); idle(1, 1, 0, 3);
    idle(0, 1, 0, 2); idle(0, 1, 0, 2); idle(1, 1, 0, 2);
    idle(0, 1, 0, 1); idle(0, 1, 0, 1); idle(1, 1, 0, 1);
    idle(0, 0, 1, 0);
    idle(0, 0, 0, 0);
    // 5: STEP 0 pulses step_done only; HALT after 2 pulses aborts silently
    v(0, 0, 1, STEP, 0, 0, 0, 1, 0);
    idle(0, 0, 0, 0);
    v(0, 0, 1, STEP, 4, 0, 1, 0, 4);
    idle(0, 1, 0, 4); idle(1, 1, 0, 4);
    idle(0, 1, 0, 3); idle(0, 1, 0, 3); idle(1, 1, 0, 3);
    idle(0, 1, 0, 2);
    v(0, 0, 1, HALT, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    // RUN while stepping converts with phase kept and remaining cleared
    v(0, 0, 1, STEP, 3, 0, 1, 0, 3);
    v(0, 0, 1, RUN, 0,  0, 1, 0, 0);
    idle(1, 1, 0, 0);
    idle(0, 1, 0, 0); idle(0, 1, 0, 0); idle(1, 1, 0, 0);
    idle(0, 1, 0, 0); idle(0, 1, 0, 0); idle(1, 1, 0, 0);
    v(0, 0, 1, HALT, 0, 0, 0, 0, 0);
    // STEP on the auto-halt edge wins: no step_done, reload, phase wraps
    v(0, 0, 1, STEP, 1, 0, 1, 0, 1);
    idle(0, 1, 0, 1); idle(1, 1, 0, 1);
    v(0, 0, 1, STEP, 2, 0, 1, 0, 2);
    idle(0, 1, 0, 2); idle(1, 1, 0, 2);
    idle(0, 1, 0, 1); idle(0, 1, 0, 1); idle(1, 1, 0, 1);
    idle(0, 0, 1, 0);
    idle(0, 0, 0, 0);
    // reserved op is ignored
    v(0, 0, 1, RSVD, 9, 0, 0, 0, 0);

    // reset state
    @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 16'd0);
    check("cfg_ready", {15'd0, bus.cfg_ready}, 16'd1);
    check("cmd_ready", {15'd0, bus.cmd_ready}, 16'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].cv, vecs[i].cd, vecs[i].mv, vecs[i].op, vecs[i].cnt);
      check_outs($sformatf("vec%0d", i), vecs[i].ece, vecs[i].erun,
                 vecs[i].esd, vecs[i].erem);
    end

    // ten full periods at div=3 from a fresh RUN
    cycle(1'b1, 8'd3, 1'b0, HALT, 16'd0);
    cycle(1'b0, 8'd0, 1'b1, RUN, 16'd0);
    check_outs("div3.start", 1'b0, 1'b1, 1'b0, 16'd0);
    for (int p = 0; p < 10; p++) begin
      for (int k = 1; k <= 4; k++) begin
        cycle(1'b0, 8'd0, 1'b0, HALT, 16'd0);
        check_outs($sformatf("div3.p%0d.k%0d", p, k), (k == 3), 1'b1, 1'b0, 16'd0);
      end
    end
    // cfg offered on the wrap edge itself applies on that edge
    cycle(1'b0, 8'd0, 1'b0, HALT, 16'd0);
    cycle(1'b0, 8'd0, 1'b0, HALT, 16'd0);
    cycle(1'b0, 8'd0, 1'b0, HALT, 16'd0);
    check_outs("wrapcfg.pre", 1'b1, 1'b1, 1'b0, 16'd0);
    cycle(1'b1, 8'd1, 1'b0, HALT, 16'd0);
    check_outs("wrapcfg.edge", 1'b0, 1'b1, 1'b0, 16'd0);
    cycle(1'b0, 8'd0, 1'b0, HALT, 16'd0);
    check_outs("wrapcfg.ce", 1'b1, 1'b1, 1'b0, 16'd0);
    cycle(1'b0, 8'd0, 1'b0, HALT, 16'd0);
    check_outs("wrapcfg.gap", 1'b0, 1'b1, 1'b0, 16'd0);
    cycle(1'b0, 8'd0, 1'b1, HALT, 16'd0);

    // asynchronous reset mid-RUN at div=2
    cycle(1'b1, 8'd2, 1'b0, HALT, 16'd0);
    cycle(1'b0, 8'd0, 1'b1, RUN, 16'd0);
    cycle(1'b0, 8'd0, 1'b0, HALT, 16'd0);
    cycle(1'b0, 8'd0, 1'b0, HALT, 16'd0);
    check_outs("arst.before", 1'b1, 1'b1, 1'b0, 16'd0);
    #1;
    rst = 1'b1;
    #1;
    check_outs("arst.during", 1'b0, 1'b0, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b0, 8'd0, 1'b1, RUN, 16'd0);
    check_outs("arst.run0", 1'b1, 1'b1, 1'b0, 16'd0);
    cycle(1'b0, 8'd0, 1'b0, HALT, 16'd0);
    check_outs("arst.run1", 1'b1, 1'b1, 1'b0, 16'd0);
    cycle(1'b0, 8'd0, 1'b0, HALT, 16'd0);
    check_outs("arst.run2", 1'b1, 1'b1, 1'b0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
